// File: rtl/ahb_pkg.sv
// Shared AHB types and constants: transfer types, response codes,
// default-slave FSM states and the width of the address region field.
package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   localparam int REGION_BITS = 4;

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers active (NONSEQ/SEQ) transfers to unmapped
// space with the two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY.
module ahb_default_slave (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sel,
   input  logic [1:0] htrans,
   input  logic       hready,
   output logic       hreadyout,
   output logic       hresp
);
   import ahb_pkg::*;

   ds_state_t state;
   ds_state_t state_nxt;
   logic      accept;
   logic      unused_htrans;

   // Only NONSEQ/SEQ (htrans[1]) accepted while the bus is ready start an error.
   assign accept        = sel & htrans[1] & hready;
   assign unused_htrans = htrans[0];

   // State register; reset aborts any response in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= DS_IDLE;
      else       state <= state_nxt;
   end

   // Next state and response outputs for the two-cycle ERROR sequence.
   always_comb begin
      state_nxt = state;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      case (state)
         DS_IDLE: begin
            if (accept) state_nxt = DS_ERR1;
         end
         DS_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_nxt = DS_ERR2;
         end
         DS_ERR2: begin
            hresp     = HRESP_ERROR;
            state_nxt = accept ? DS_ERR1 : DS_IDLE;
         end
         default: state_nxt = DS_IDLE;
      endcase
   end

endmodule

// File: rtl/definition.sv
// Bus-wide AHB sizing macros shared by the decoder/response-mux slice.
// Each macro is guarded so a build can override it on the command line.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef AHB_SLAVE_DEVICES
`define AHB_SLAVE_DEVICES 4
`endif

// File: rtl/ahb_resp_mux.sv
// AHB address decoder and slave-to-master response multiplexer.
// Decodes the top address nibble into a one-hot select (last bit = built-in
// default slave), registers the data-phase owner and muxes its response back.
// Optional macro AHB_RESP_MUX_ERR_CNT_EN adds a saturating ERROR counter err_cnt.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef AHB_SLAVE_DEVICES
`define AHB_SLAVE_DEVICES 4
`endif

module ahb_resp_mux #(
   parameter int ADDR_WIDTH    = `AHB_ADDR_WIDTH,
   parameter int DATA_WIDTH    = `AHB_DATA_WIDTH,
   parameter int SLAVE_DEVICES = `AHB_SLAVE_DEVICES
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [ADDR_WIDTH-1:0]               haddr,
   input  logic [1:0]                          htrans,
   output logic [SLAVE_DEVICES:0]              selx,
   output logic [$clog2(SLAVE_DEVICES):0]      multip_sel,
   input  logic [SLAVE_DEVICES*DATA_WIDTH-1:0] s_hrdata,
   input  logic [SLAVE_DEVICES-1:0]            s_hreadyout,
   input  logic [SLAVE_DEVICES-1:0]            s_hresp,
   output logic [DATA_WIDTH-1:0]               hrdata,
   output logic                                master_ready,
   output logic                                hresp
`ifdef AHB_RESP_MUX_ERR_CNT_EN
   ,
   output logic [15:0]                         err_cnt
`endif
);
   import ahb_pkg::*;

   localparam int SEL_W = $clog2(SLAVE_DEVICES) + 1;

   logic [REGION_BITS-1:0] region;
   logic [SEL_W-1:0]       sel_idx;
   logic                   ds_hreadyout;
   logic                   ds_hresp;
   logic                   unused_addr;

   assign region      = haddr[ADDR_WIDTH-1 -: REGION_BITS];
   assign unused_addr = ^haddr[ADDR_WIDTH-REGION_BITS-1:0];

   // Address decode: regions 1..SLAVE_DEVICES map to real slaves, all else to the default slave.
   always_comb begin
      sel_idx = SEL_W'(SLAVE_DEVICES);
      if (int'(region) >= 1 && int'(region) <= SLAVE_DEVICES)
         sel_idx = SEL_W'(int'(region) - 1);
      selx = '0;
      for (int i = 0; i <= SLAVE_DEVICES; i++)
         selx[i] = (int'(sel_idx) == i);
   end

   // Data-phase owner: advances only when the current data phase completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             multip_sel <= SEL_W'(SLAVE_DEVICES);
      else if (master_ready) multip_sel <= sel_idx;
   end

   ahb_default_slave u_default_slave (
      .clk       (clk),
      .rstn      (rstn),
      .sel       (selx[SLAVE_DEVICES]),
      .htrans    (htrans),
      .hready    (master_ready),
      .hreadyout (ds_hreadyout),
      .hresp     (ds_hresp)
   );

   // Response mux: real slave when owner is in range, otherwise default slave with zero data.
   always_comb begin
      hrdata       = '0;
      master_ready = ds_hreadyout;
      hresp        = ds_hresp;
      for (int i = 0; i < SLAVE_DEVICES; i++) begin
         if (int'(multip_sel) == i) begin
            hrdata       = s_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
            master_ready = s_hreadyout[i];
            hresp        = s_hresp[i];
         end
      end
   end

`ifdef AHB_RESP_MUX_ERR_CNT_EN
   // Count completed ERROR responses (final, ready cycle), saturating at all-ones.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         err_cnt <= '0;
      else if (master_ready && hresp == HRESP_ERROR && err_cnt != 16'hFFFF)
         err_cnt <= err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux (4 slaves, 32-bit data): directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_ahb_resp_mux;

   logic         clk;
   logic         rstn;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic [4:0]   selx;
   logic [2:0]   multip_sel;
   logic [127:0] s_hrdata;
   logic [3:0]   s_hreadyout;
   logic [3:0]   s_hresp;
   logic [31:0]  hrdata;
   logic         master_ready;
   logic         hresp;
`ifdef AHB_RESP_MUX_ERR_CNT_EN
   logic [15:0]  err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_owner;   // data-phase owner: 0..3 real slave, 4 default slave
   int m_err;     // default-slave ERROR cycles still to deliver (2, 1 or 0)
   int m_cnt;     // completed ERROR responses, saturating

   logic [4:0]  exp_selx;
   logic        exp_ready;
   logic        exp_resp;
   logic [31:0] exp_data;
   logic [2:0]  exp_sel;

   ahb_resp_mux #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .SLAVE_DEVICES (4)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .haddr        (haddr),
      .htrans       (htrans),
      .selx         (selx),
      .multip_sel   (multip_sel),
      .s_hrdata     (s_hrdata),
      .s_hreadyout  (s_hreadyout),
      .s_hresp      (s_hresp),
      .hrdata       (hrdata),
      .master_ready (master_ready),
      .hresp        (hresp)
`ifdef AHB_RESP_MUX_ERR_CNT_EN
      ,
      .err_cnt      (err_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int decode(input logic [31:0] a);
      int r;
      r = int'(a[31:28]);
      return (r >= 1 && r <= 4) ? r - 1 : 4;
   endfunction

   task automatic model_reset();
      m_owner = 4;
      m_err   = 0;
      m_cnt   = 0;
   endtask

   task automatic eval();
      exp_selx = 5'b00001 << decode(haddr);
      exp_sel  = 3'(m_owner);
      if (m_owner < 4) begin
         exp_ready = s_hreadyout[m_owner];
         exp_resp  = s_hresp[m_owner];
         exp_data  = s_hrdata[m_owner*32 +: 32];
      end else begin
         exp_ready = (m_err != 2);
         exp_resp  = (m_err != 0);
         exp_data  = 32'h0;
      end
   endtask

   // advance one clock, updating the model with the values seen at the edge
   task automatic tick();
      eval();
      @(posedge clk);
      if (exp_ready && exp_resp && m_cnt < 65535) m_cnt++;
      if (m_err == 2)
         m_err = 1;
      else if (exp_ready && decode(haddr) == 4 && htrans[1])
         m_err = 2;
      else
         m_err = 0;
      if (exp_ready) m_owner = decode(haddr);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_tests++; if (master_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", master_ready); end
      n_tests++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got %b want 0", hresp); end
      n_tests++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h want 0", hrdata); end
      n_tests++; if (multip_sel !== 3'd4) begin n_fail++; $display("FAIL reset_multip_sel got %0d want 4", multip_sel); end
      n_tests++; if (selx !== 5'b10000) begin n_fail++; $display("FAIL reset_selx got %b want 10000", selx); end
`ifdef AHB_RESP_MUX_ERR_CNT_EN
      n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
`endif
      @(negedge clk);
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_mapped_read();
      s_hrdata[31:0] = 32'hA5A5_0001;
      haddr = 32'h1000_0000; htrans = 2'd2;
      @(negedge clk);
      n_tests++; if (selx !== 5'b00001) begin n_fail++; $display("FAIL map_selx got %b want 00001", selx); end
      tick();
      haddr = 32'h0; htrans = 2'd0;
      @(negedge clk);
      n_tests++; if (multip_sel !== 3'd0) begin n_fail++; $display("FAIL map_multip_sel got %0d want 0", multip_sel); end
      n_tests++; if (hrdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL map_hrdata got %h want a5a50001", hrdata); end
      n_tests++; if (master_ready !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL map_resp got rdy=%b resp=%b want 1/0", master_ready, hresp); end
      tick();
   endtask

   task automatic test_unmapped_error();
      haddr = 32'h0000_0100; htrans = 2'd2;
      @(negedge clk);
      n_tests++; if (selx !== 5'b10000) begin n_fail++; $display("FAIL unmap_selx got %b want 10000", selx); end
      tick();
      haddr = 32'h1000_0000; htrans = 2'd0;
      @(negedge clk);
      n_tests++; if (master_ready !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL unmap_cycle1 got rdy=%b resp=%b want 0/1", master_ready, hresp); end
      tick();
      @(negedge clk);
      n_tests++; if (master_ready !== 1'b1 || hresp !== 1'b1) begin n_fail++; $display("FAIL unmap_cycle2 got rdy=%b resp=%b want 1/1", master_ready, hresp); end
      tick();
      @(negedge clk);
      n_tests++; if (master_ready !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL unmap_after got rdy=%b resp=%b want 1/0", master_ready, hresp); end
      tick();
   endtask

   task automatic test_slave_wait();
      haddr = 32'h2000_0000; htrans = 2'd2;
      tick();
      s_hreadyout[1] = 1'b0;
      haddr = 32'h3000_0000; htrans = 2'd2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++; if (multip_sel !== 3'd1 || master_ready !== 1'b0) begin n_fail++; $display("FAIL wait_hold%0d got sel=%0d rdy=%b want 1/0", k, multip_sel, master_ready); end
         n_tests++; if (selx !== 5'b00100) begin n_fail++; $display("FAIL wait_selx%0d got %b want 00100", k, selx); end
         tick();
      end
      s_hreadyout[1] = 1'b1;
      @(negedge clk);
      n_tests++; if (multip_sel !== 3'd1 || master_ready !== 1'b1) begin n_fail++; $display("FAIL wait_release got sel=%0d rdy=%b want 1/1", multip_sel, master_ready); end
      tick();
      htrans = 2'd0;
      @(negedge clk);
      n_tests++; if (multip_sel !== 3'd2) begin n_fail++; $display("FAIL wait_next got %0d want 2", multip_sel); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [4:0] want_rdy;
      logic [4:0] want_resp;
      want_rdy  = 5'b11010;   // bit k = cycle k
      want_resp = 5'b01111;
      haddr = 32'hF000_0000; htrans = 2'd2;
      tick();
      haddr = 32'hF000_0004; htrans = 2'd2;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_tests++; if (master_ready !== want_rdy[k] || hresp !== want_resp[k]) begin n_fail++; $display("FAIL b2b_cycle%0d got rdy=%b resp=%b want %b/%b", k, master_ready, hresp, want_rdy[k], want_resp[k]); end
         tick();
         if (k == 1) begin haddr = 32'h0; htrans = 2'd0; end
      end
   endtask

   task automatic test_idle_unmapped();
      haddr = 32'h0; htrans = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_tests++; if (master_ready !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL idle_cycle%0d got rdy=%b resp=%b want 1/0", k, master_ready, hresp); end
         n_tests++; if (selx !== 5'b10000 || multip_sel !== 3'd4) begin n_fail++; $display("FAIL idle_sel%0d got selx=%b sel=%0d want 10000/4", k, selx, multip_sel); end
         tick();
      end
   endtask

   task automatic test_reset_mid_error();
      haddr = 32'h0000_0100; htrans = 2'd2;
      tick();
      haddr = 32'h0; htrans = 2'd0;
      @(negedge clk);
      n_tests++; if (master_ready !== 1'b0 || hresp !== 1'b1) begin n_fail++; $display("FAIL rst_pre got rdy=%b resp=%b want 0/1", master_ready, hresp); end
      #1 rstn = 1'b0;
      #1;
      n_tests++; if (master_ready !== 1'b1 || hresp !== 1'b0) begin n_fail++; $display("FAIL rst_abort got rdy=%b resp=%b want 1/0", master_ready, hresp); end
      n_tests++; if (multip_sel !== 3'd4 || hrdata !== 32'h0) begin n_fail++; $display("FAIL rst_abort_sel got sel=%0d data=%h want 4/0", multip_sel, hrdata); end
`ifdef AHB_RESP_MUX_ERR_CNT_EN
      n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
`endif
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         haddr  = {4'($urandom_range(0, 15)), 28'($urandom)};
         htrans = 2'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) begin
            s_hreadyout[i]     = ($urandom_range(0, 3) != 0);
            s_hresp[i]         = ($urandom_range(0, 7) == 0);
            s_hrdata[i*32 +: 32] = $urandom;
         end
         eval();
         @(negedge clk);
         n_tests++; if (selx !== exp_selx) begin n_fail++; $display("FAIL rnd_selx@%0d got %b want %b", k, selx, exp_selx); end
         n_tests++; if (multip_sel !== exp_sel) begin n_fail++; $display("FAIL rnd_multip_sel@%0d got %0d want %0d", k, multip_sel, exp_sel); end
         n_tests++; if (hrdata !== exp_data) begin n_fail++; $display("FAIL rnd_hrdata@%0d got %h want %h", k, hrdata, exp_data); end
         n_tests++; if (master_ready !== exp_ready || hresp !== exp_resp) begin n_fail++; $display("FAIL rnd_resp@%0d got rdy=%b resp=%b want %b/%b", k, master_ready, hresp, exp_ready, exp_resp); end
`ifdef AHB_RESP_MUX_ERR_CNT_EN
         n_tests++; if (err_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_err_cnt@%0d got %0d want %0d", k, err_cnt, m_cnt); end
`endif
         tick();
      end
   endtask

   initial begin
      rstn        = 1'b0;
      haddr       = 32'h0;
      htrans      = 2'd0;
      s_hrdata    = '0;
      s_hreadyout = 4'hF;
      s_hresp     = 4'h0;
      model_reset();
      test_reset();
      test_mapped_read();
      test_unmapped_error();
      test_slave_wait();
      test_back_to_back();
      test_idle_unmapped();
      test_reset_mid_error();
      s_hreadyout = 4'hF;
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- AHB address decoder plus slave-to-master response multiplexer.
- Sits between the AHB master and N slaves; drives the decoder_if signals (addr, selx, master_ready, multip_sel).
- Decodes the address phase into a one-hot select, registers the data-phase owner, and muxes the data-phase response back to the master.
- Contains a built-in default slave that returns a two-cycle ERROR for active transfers to unmapped addresses.

Parameters:
- ADDR_WIDTH, `AHB_ADDR_WIDTH (32), address width.
- DATA_WIDTH, `AHB_DATA_WIDTH (32), read data width.
- SLAVE_DEVICES, `AHB_SLAVE_DEVICES (4), number of real slaves, 1..15.

Ports:
- clk  in  1  bus clock
- rstn  in  1  asynchronous active-low reset
- haddr  in  ADDR_WIDTH  master address (address phase)
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- selx  out  SLAVE_DEVICES+1  one-hot address-phase select; bit SLAVE_DEVICES = default slave
- multip_sel  out  $clog2(SLAVE_DEVICES)+1  registered data-phase slave index
- s_hrdata  in  SLAVE_DEVICES*DATA_WIDTH  flattened slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_hreadyout  in  SLAVE_DEVICES  slave ready outputs
- s_hresp  in  SLAVE_DEVICES  slave responses (1 = ERROR)
- hrdata  out  DATA_WIDTH  muxed read data to master
- master_ready  out  1  muxed HREADY to master and all slaves
- hresp  out  1  muxed response to master

Behaviour:
- Decode (combinational):
  - region = haddr[ADDR_WIDTH-1 -: 4].
  - region r in 1..SLAVE_DEVICES sets selx[r-1]; any other region sets selx[SLAVE_DEVICES].
  - Exactly one selx bit is high at all times, independent of htrans.
- Data-phase register:
  - On a clk edge with master_ready=1, multip_sel loads the encoded selx index.
  - With master_ready=0, multip_sel holds.
  - Reset value: SLAVE_DEVICES (default slave).
- Response mux (combinational on multip_sel):
  - multip_sel < SLAVE_DEVICES: hrdata, master_ready and hresp come from that slave.
  - Otherwise: they come from the default slave; hrdata is always 0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2; reset state DS_IDLE.
  - DS_IDLE: ready=1, resp=0.
    - Goes to DS_ERR1 when selx[SLAVE_DEVICES]=1, htrans[1]=1 and master_ready=1.
  - DS_ERR1: ready=0, resp=1; always goes to DS_ERR2.
  - DS_ERR2: ready=1, resp=1.
    - Goes to DS_ERR1 if another unmapped NONSEQ/SEQ is accepted in this cycle; otherwise goes to DS_IDLE.
  - IDLE/BUSY transfers to unmapped space: zero-wait OKAY, no state change.
- Reset outputs (rstn=0): master_ready=1, hresp=0, hrdata=0, multip_sel=SLAVE_DEVICES.
- Reset asserted mid-transfer (any FSM state or slave wait) aborts immediately to the reset values; no pending response survives.
- Simultaneous events:
  - A slave wait (s_hreadyout=0) stalls address-phase acceptance; selx still reflects the current haddr.
  - The FSM does not advance from DS_IDLE while master_ready=0.
- Latency: select to data-phase owner is 1 cycle. Unmapped ERROR is always exactly 2 data-phase cycles.

Optional Feature:
- Macro: AHB_RESP_MUX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [15:0].
  - err_cnt increments by 1 on every cycle where master_ready=1 and hresp=1 (final cycle of any ERROR, default slave or real slave).
  - Saturates at 16'hFFFF; reset value 0.
- When not defined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- definition.sv supplies AHB_ADDR_WIDTH, AHB_DATA_WIDTH, AHB_SLAVE_DEVICES.
- Package ahb_pkg holds:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ)
  - HRESP_OKAY/HRESP_ERROR constants
  - ds_state_t enum (DS_IDLE/DS_ERR1/DS_ERR2)
  - REGION_BITS = 4
- Sub-module ahb_default_slave holds the FSM.
  - Inputs: clk, rstn, sel, htrans, hready.
  - Outputs: hreadyout, hresp.
- Decode, data-phase register, mux and optional counter stay in the top.

Test Plan (SLAVE_DEVICES=4, DATA_WIDTH=32):
- haddr=0x1000_0000, NONSEQ, all slaves ready, slave0 data 0xA5A5_0001:
  - selx=5'b00001 in the same cycle.
  - Next cycle multip_sel=0 and hrdata=0xA5A5_0001.
- haddr=0x0000_0100, NONSEQ:
  - selx=5'b10000.
  - Data cycle 1: master_ready=0, hresp=1. Data cycle 2: master_ready=1, hresp=1.
  - Then back to OKAY.
- Slave1 (haddr=0x2000_0000) holds s_hreadyout=0 for 3 cycles while haddr moves to 0x3000_0000:
  - multip_sel stays 1 for 3 cycles, becomes 2 one cycle after the release.
- Back-to-back unmapped NONSEQ at 0xF000_0000 and 0xF000_0004:
  - FSM sequence ERR1, ERR2, ERR1, ERR2, IDLE; hresp=1 for 4 consecutive cycles.
- htrans=IDLE at 0x0000_0000:
  - master_ready=1 and hresp=0 every cycle; FSM stays DS_IDLE.
- rstn pulled low during DS_ERR1:
  - Same cycle: master_ready=1, hresp=0, multip_sel=4.
  - With AHB_RESP_MUX_ERR_CNT_EN: err_cnt=0.
